// File: rtl/spi_flash_mux_arbiter_if.sv
`timescale 1ns/1ps
// Signal bundle around spi_flash_mux_arbiter: host pins, BMC pins with req/gnt, flash pins, status.
// "slave" is the arbiter's view of the bundle; "master" is the view of everything around it.
interface spi_flash_mux_arbiter_if #(
    parameter int CNT_W = 8
);
    logic             m0_sclk;
    logic             m0_mosi;
    logic             m0_ss_n;
    logic             m0_miso;
    logic             m1_req;
    logic             m1_gnt;
    logic             m1_sclk;
    logic             m1_mosi;
    logic             m1_ss_n;
    logic             m1_miso;
    logic             flash_sclk;
    logic             flash_mosi;
    logic             flash_ss_n;
    logic             flash_miso;
    logic [1:0]       owner;
    logic [CNT_W-1:0] conflict_cnt;
    logic             conflict_clr;

    modport slave (
        input  m0_sclk, m0_mosi, m0_ss_n,
        input  m1_req, m1_sclk, m1_mosi, m1_ss_n,
        input  flash_miso, conflict_clr,
        output m0_miso, m1_gnt, m1_miso,
        output flash_sclk, flash_mosi, flash_ss_n,
        output owner, conflict_cnt
    );

    modport master (
        output m0_sclk, m0_mosi, m0_ss_n,
        output m1_req, m1_sclk, m1_mosi, m1_ss_n,
        output flash_miso, conflict_clr,
        input  m0_miso, m1_gnt, m1_miso,
        input  flash_sclk, flash_mosi, flash_ss_n,
        input  owner, conflict_cnt
    );
endinterface

// File: rtl/spi_flash_mux_arbiter.sv
`timescale 1ns/1ps
// Shares one SPI flash between the host SoC (master 0, raw pins, priority) and the BMC
// (master 1, req/gnt). Ownership changes only between frames, with a guard gap after release.
module spi_flash_mux_arbiter #(
    parameter int SYNC_STAGES  = 2,
    parameter int GUARD_CYCLES = 4,
    parameter bit CPOL         = 1'b0,
    parameter int CNT_W        = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    spi_flash_mux_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1, GUARD} state_t;

    localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYCLES);

    state_t                 state;
    logic [SYNC_STAGES-1:0] m0_sync;
    logic [SYNC_STAGES-1:0] m1_sync;
    logic                   req0;
    logic                   act1;
    logic                   req0_q;
    logic                   conflict_evt;
    logic [7:0]             guard_cnt;
    logic                   from_own1;
    logic                   gnt_q;
    logic [1:0]             owner_q;
    logic [CNT_W-1:0]       cnt_q;

    // Chip selects idle high, so the synchronizers reset to 1 to avoid a phantom request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m0_sync <= '1;
            m1_sync <= '1;
            req0_q  <= 1'b0;
        end else begin
            m0_sync <= {m0_sync[SYNC_STAGES-2:0], bus.m0_ss_n};
            m1_sync <= {m1_sync[SYNC_STAGES-2:0], bus.m1_ss_n};
            req0_q  <= req0;
        end
    end

    assign req0 = ~m0_sync[SYNC_STAGES-1];
    assign act1 = ~m1_sync[SYNC_STAGES-1];

    // NOTE: every register here updates with <= so all flops sample the same pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            guard_cnt <= '0;
            from_own1 <= 1'b0;
            gnt_q     <= 1'b0;
            owner_q   <= 2'b00;
        end else begin
            gnt_q   <= (state == OWN1);
            owner_q <= (state == OWN0) ? 2'b01 : (state == OWN1) ? 2'b10 : 2'b00;
            unique case (state)
                IDLE: begin
                    if (req0) begin
                        state <= OWN0;
                    end else if (bus.m1_req) begin
                        state <= OWN1;
                    end
                end
                OWN0: begin
                    if (!req0) begin
                        state     <= GUARD;
                        guard_cnt <= GUARD_LOAD;
                        from_own1 <= 1'b0;
                    end
                end
                OWN1: begin
                    if (!bus.m1_req && !act1) begin
                        state     <= GUARD;
                        guard_cnt <= GUARD_LOAD;
                        from_own1 <= 1'b1;
                    end
                end
                GUARD: begin
                    if (guard_cnt == 8'd1) begin
                        state     <= IDLE;
                        guard_cnt <= '0;
                        from_own1 <= 1'b0;
                    end else begin
                        guard_cnt <= guard_cnt - 8'd1;
                    end
                end
            endcase
        end
    end

    assign conflict_evt = req0 & ~req0_q & ((state == OWN1) | ((state == GUARD) & from_own1));

    // A clear takes precedence over a coincident conflict event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (bus.conflict_clr) begin
            cnt_q <= '0;
        end else if (conflict_evt && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // The mux decodes the state register, not owner_q, so the host sees SYNC_STAGES+1 latency
    // and reset releases flash_ss_n asynchronously.
    always_comb begin
        // NOTE: defaults first so no path through this block leaves an output unassigned (no latch).
        bus.flash_ss_n = 1'b1;
        bus.flash_sclk = CPOL;
        bus.flash_mosi = 1'b0;
        bus.m0_miso    = 1'b1;
        bus.m1_miso    = 1'b1;
        case (state)
            OWN0: begin
                bus.flash_ss_n = bus.m0_ss_n;
                bus.flash_sclk = bus.m0_sclk;
                bus.flash_mosi = bus.m0_mosi;
                bus.m0_miso    = bus.flash_miso;
            end
            OWN1: begin
                bus.flash_ss_n = bus.m1_ss_n;
                bus.flash_sclk = bus.m1_sclk;
                bus.flash_mosi = bus.m1_mosi;
                bus.m1_miso    = bus.flash_miso;
            end
            default: begin
            end
        endcase
    end

    assign bus.m1_gnt       = gnt_q;
    assign bus.owner        = owner_q;
    assign bus.conflict_cnt = cnt_q;
endmodule
